// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32 load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_REQ2,
    S_WAIT2,
    S_RESP
  } lsu_state_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Lanes inside the first (or only) word touched by the access.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] offset);
    return size_mask(size) << offset;
  endfunction

  // Lanes that spill into the following word; zero when nothing crosses.
  function automatic logic [3:0] be_spill(input logic [1:0] size, input logic [1:0] offset);
    return size_mask(size) >> (3'd4 - {1'b0, offset});
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Picks the addressed bytes out of a {hi, lo} word pair and sign/zero-extends them.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [63:0] pair;
  logic [31:0] word;

  assign pair = {hi_i, lo_i};
  assign word = pair[{1'b0, off_i, 3'b000} +: 32];

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{word[7]}}, word[7:0]};
      F3_H:    data_o = {{16{word[15]}}, word[15:0]};
      F3_BU:   data_o = {24'b0, word[7:0]};
      F3_HU:   data_o = {16'b0, word[15:0]};
      default: data_o = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32IM memory-stage LSU: one request at a time onto a word-aligned bus.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned accesses into two words.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [RD_W-1:0]   resp_rd,
  output logic              resp_err
);

  lsu_state_t        state_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [RD_W-1:0]   rd_q;
  logic              req_ready_q, mem_req_q, mem_we_q, resp_valid_q, resp_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q, resp_rdata_q;
  logic [RD_W-1:0]   resp_rd_q;

  logic [1:0]        size;
  logic              legal, misal, go_err;
  logic [ADDR_W-1:0] addr_word;
  logic [31:0]       wdata_fmt, load_data, ld_hi, ld_lo;

  assign size      = req_funct3[1:0];
  assign addr_word = {req_addr[ADDR_W-1:2], 2'b00};
  assign misal     = (size == 2'd1 && req_addr[0]) ||
                     (size == 2'd2 && req_addr[1:0] != 2'b00);

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !req_we;
      default:          legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        split_q;
  logic [3:0]  be2_q;
  logic [31:0] rdata_lo_q;
  logic [4:0]  sh;
  logic [31:0] wdata_rot;

  // A rotated word serves both halves: each access only enables its own lanes.
  assign sh        = {req_addr[1:0], 3'b000};
  assign wdata_rot = (req_wdata << sh) | (req_wdata >> (6'd32 - {1'b0, sh}));
  assign go_err    = !legal;
  assign ld_hi     = (state_q == S_WAIT2) ? mem_rdata  : 32'b0;
  assign ld_lo     = (state_q == S_WAIT2) ? rdata_lo_q : mem_rdata;
`else
  assign go_err    = !legal || misal;
  assign ld_hi     = 32'b0;
  assign ld_lo     = mem_rdata;
`endif

  always_comb begin
    case (size)
      2'd0:    wdata_fmt = {4{req_wdata[7:0]}};
      2'd1:    wdata_fmt = {2{req_wdata[15:0]}};
      default: wdata_fmt = req_wdata;
    endcase
`ifdef LSU_MISALIGNED_SPLIT_EN
    if (misal) wdata_fmt = wdata_rot;
`endif
  end

  lsu_load_align u_align (
    .hi_i     (ld_hi),
    .lo_i     (ld_lo),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      f3_q         <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q      <= 1'b0;
      be2_q        <= '0;
      rdata_lo_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          req_ready_q <= 1'b0;
          f3_q        <= req_funct3;
          off_q       <= req_addr[1:0];
          rd_q        <= req_rd;
          if (go_err) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            resp_rd_q    <= req_rd;
          end else begin
            state_q     <= S_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_we;
            mem_addr_q  <= addr_word;
            mem_be_q    <= be_gen(size, req_addr[1:0]);
            mem_wdata_q <= wdata_fmt;
`ifdef LSU_MISALIGNED_SPLIT_EN
            // Halfword at offset 1 stays inside one word, so no second access.
            split_q     <= misal && (be_spill(size, req_addr[1:0]) != 4'b0);
            be2_q       <= be_spill(size, req_addr[1:0]);
`endif
          end
        end
        S_REQ: if (mem_gnt) begin
          mem_req_q <= 1'b0;
          if (!mem_we_q) state_q <= S_WAIT;
`ifdef LSU_MISALIGNED_SPLIT_EN
          else if (split_q) begin
            state_q    <= S_REQ2;
            mem_req_q  <= 1'b1;
            mem_addr_q <= mem_addr_q + ADDR_W'(4);
            mem_be_q   <= be2_q;
          end
`endif
          else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= rd_q;
          end
        end
        S_WAIT: if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (split_q) begin
            state_q    <= S_REQ2;
            rdata_lo_q <= mem_rdata;
            mem_req_q  <= 1'b1;
            mem_addr_q <= mem_addr_q + ADDR_W'(4);
            mem_be_q   <= be2_q;
          end else
`endif
          begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data;
            resp_rd_q    <= rd_q;
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        S_REQ2: if (mem_gnt) begin
          mem_req_q <= 1'b0;
          if (!mem_we_q) state_q <= S_WAIT2;
          else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= rd_q;
          end
        end
        S_WAIT2: if (mem_rvalid) begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_data;
          resp_rd_q    <= rd_q;
        end
`endif
        S_RESP: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed, table-driven bench for lsu_mem_stage plus hand-written multi-cycle sequences.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;

  always #5 clk = ~clk;

  lsu_mem_stage #(.ADDR_W(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rd0, rd1;
    int          nacc;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];
  int checks = 0, errors = 0;

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rd0, logic [31:0] rd1, int nacc,
                              logic [31:0] a0, logic [3:0] be0, logic [31:0] wd,
                              logic [31:0] a1, logic [3:0] be1, logic [31:0] exp_rdata, logic exp_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd0 = rd0; v.rd1 = rd1;
    v.nacc = nacc; v.a0 = a0; v.be0 = be0; v.wd = wd; v.a1 = a1; v.be1 = be1;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k, lat, busy_ready;
    bit pend, done;
    logic [31:0] ga[2], gw[2];
    logic [3:0]  gb[2];
    logic [4:0]  tag;
    tag = 5'(idx + 1);
    ga[0] = '0; ga[1] = '0; gw[0] = '0; gw[1] = '0; gb[0] = '0; gb[1] = '0;
    @(negedge clk);
    chk($sformatf("v%0d ready_idle", idx), 32'(req_ready), 1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = tag;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0; lat = -1; pend = 1'b0; done = 1'b0; busy_ready = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (resp_valid) begin
        lat = cyc; done = 1'b1;
      end else begin
        if (req_ready) busy_ready++;
        if (pend) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (k == 1) ? v.rd0 : v.rd1;
          pend = 1'b0;
        end else if (mem_req) begin
          if (k < 2) begin ga[k] = mem_addr; gb[k] = mem_be; gw[k] = mem_wdata; end
          k++;
          mem_gnt = 1'b1;
          pend = !mem_we;
        end
        @(negedge clk);
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk($sformatf("v%0d resp_seen", idx), 32'(done), 1);
    chk($sformatf("v%0d ready_busy", idx), 32'(busy_ready), 0);
    chk($sformatf("v%0d latency", idx), 32'(lat),
        32'((v.exp_err || v.we) ? v.nacc : 2 * v.nacc));
    chk($sformatf("v%0d n_access", idx), 32'(k), 32'(v.nacc));
    if (v.nacc > 0) begin
      chk($sformatf("v%0d addr0", idx), ga[0], v.a0);
      chk($sformatf("v%0d be0", idx), 32'(gb[0]), 32'(v.be0));
      if (v.we) chk($sformatf("v%0d wdata0", idx), gw[0], v.wd);
    end
    if (v.nacc > 1) begin
      chk($sformatf("v%0d addr1", idx), ga[1], v.a1);
      chk($sformatf("v%0d be1", idx), 32'(gb[1]), 32'(v.be1));
      if (v.we) chk($sformatf("v%0d wdata1", idx), gw[1], v.wd);
    end
    chk($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d err", idx), 32'(resp_err), 32'(v.exp_err));
    chk($sformatf("v%0d rd_tag", idx), 32'(resp_rd), 32'(tag));
    @(negedge clk);
    chk($sformatf("v%0d resp_pulse", idx), 32'(resp_valid), 0);
    chk($sformatf("v%0d ready_back", idx), 32'(req_ready), 1);
  endtask

  initial begin
    int seen;
    // we f3 addr wdata rd0 rd1 nacc a0 be0 wd a1 be1 exp_rdata err
    tbl.push_back(mk(0, F3_B,  32'h103, 0, 32'h80FF1234, 0, 1, 32'h100, 4'b1000, 0, 0, 0, 32'hFFFFFF80, 0));
    tbl.push_back(mk(0, F3_HU, 32'h102, 0, 32'h80010000, 0, 1, 32'h100, 4'b1100, 0, 0, 0, 32'h00008001, 0));
    tbl.push_back(mk(1, F3_H,  32'h22, 32'h1234ABCD, 0, 0, 1, 32'h20, 4'b1100, 32'hABCDABCD, 0, 0, 0, 0));
    tbl.push_back(mk(1, F3_B,  32'h7, 32'h9876545A, 0, 0, 1, 32'h4, 4'b1000, 32'h5A5A5A5A, 0, 0, 0, 0));
    tbl.push_back(mk(0, F3_H,  32'h6, 0, 32'hF00D1234, 0, 1, 32'h4, 4'b1100, 0, 0, 0, 32'hFFFFF00D, 0));
    tbl.push_back(mk(0, F3_BU, 32'h1, 0, 32'h0000C300, 0, 1, 32'h0, 4'b0010, 0, 0, 0, 32'h000000C3, 0));
    tbl.push_back(mk(1, F3_W,  32'hFFFFFFFC, 32'hDEADBEEF, 0, 0, 1, 32'hFFFFFFFC, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(0, F3_B,  32'h0, 0, 32'h1234567F, 0, 1, 32'h0, 4'b0001, 0, 0, 0, 32'h0000007F, 0));
    tbl.push_back(mk(0, F3_W,  32'h200, 0, 32'h89ABCDEF, 0, 1, 32'h200, 4'b1111, 0, 0, 0, 32'h89ABCDEF, 0));
    tbl.push_back(mk(0, 3'b011, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3'b100, 32'h14, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3'b110, 32'h18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef LSU_MISALIGNED_SPLIT_EN
    tbl.push_back(mk(0, F3_W, 32'h41, 0, 32'h332211AA, 32'hBBCCDD44, 2, 32'h40, 4'b1110, 0, 32'h44, 4'b0001, 32'h44332211, 0));
    tbl.push_back(mk(0, F3_H, 32'h3, 0, 32'h7F000000, 32'h00000080, 2, 32'h0, 4'b1000, 0, 32'h4, 4'b0001, 32'hFFFF807F, 0));
    tbl.push_back(mk(1, F3_W, 32'hFFFFFFFE, 32'h11223344, 0, 0, 2, 32'hFFFFFFFC, 4'b1100, 32'h33441122, 32'h0, 4'b0011, 0, 0));
`else
    tbl.push_back(mk(0, F3_W, 32'h41, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, F3_H, 32'h3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, F3_W, 32'hFFFFFFFE, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, F3_HU, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(req_ready), 1);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst resp_valid", 32'(resp_valid), 0);
    chk("rst resp_err", 32'(resp_err), 0);
    chk("rst mem_be", 32'(mem_be), 0);
    chk("rst mem_addr", mem_addr, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // SW with grant withheld for three cycles: bus must hold steady
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h50; req_wdata = 32'hCAFEF00D; req_rd = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("hold%0d mem_req", c), 32'(mem_req), 1);
      chk($sformatf("hold%0d addr", c), mem_addr, 32'h50);
      chk($sformatf("hold%0d be", c), 32'(mem_be), 32'hF);
      chk($sformatf("hold%0d wdata", c), mem_wdata, 32'hCAFEF00D);
      chk($sformatf("hold%0d we", c), 32'(mem_we), 1);
      chk($sformatf("hold%0d ready", c), 32'(req_ready), 0);
      chk($sformatf("hold%0d resp", c), 32'(resp_valid), 0);
      mem_gnt = (c == 3);
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    chk("hold resp_valid", 32'(resp_valid), 1);
    chk("hold resp_rd", 32'(resp_rd), 7);
    chk("hold mem_req_drop", 32'(mem_req), 0);
    @(negedge clk);
    chk("hold single_resp", 32'(resp_valid), 0);

    // Stray rvalid while idle
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stray resp", 32'(resp_valid), 0);
    chk("stray ready", 32'(req_ready), 1);

    // Reset while waiting for read data; the late rvalid must be dropped
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h80; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstwait mem_req", 32'(mem_req), 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstwait in_wait", 32'(mem_req), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstwait ready", 32'(req_ready), 1);
    chk("rstwait mem_req_low", 32'(mem_req), 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    mem_rvalid = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("rstwait no_resp", 32'(seen), 0);
    chk("rstwait ready_after", 32'(req_ready), 1);
    run_vec(99, mk(0, F3_B, 32'h103, 0, 32'h80FF1234, 0, 1, 32'h100, 4'b1000, 0, 0, 0, 32'hFFFFFF80, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit for the RV32IM memory stage.
- Sits between the EX/MEM pipeline register and the external data memory.
- Accepts one byte-addressed load/store request at a time and converts it into word-aligned memory bus transactions with byte enables and lane-replicated write data.
- Waits for grant and read response, then returns sign- or zero-extended load data to writeback.

Parameters:
ADDR_W, 32, byte-address width of request and memory bus.
RD_W, 5, width of destination-register tag carried with the request.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
req_valid  input  1  pipeline request valid.
req_ready  output  1  unit can accept a request (high only in IDLE).
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  access type, RISC-V funct3 encoding.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data (low bits used for SB/SH).
req_rd  input  RD_W  destination tag, returned unchanged.
mem_req  output  1  bus request; held until granted.
mem_we  output  1  bus write.
mem_addr  output  ADDR_W  word-aligned address, bits [1:0] = 0.
mem_be  output  4  byte enables.
mem_wdata  output  32  lane-replicated write data.
mem_gnt  input  1  bus accepts current request this cycle.
mem_rvalid  input  1  read data valid; at least 1 cycle after grant.
mem_rdata  input  32  read word.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_rd  output  RD_W  tag of completed request.
resp_err  output  1  misaligned or illegal access; no bus activity occurred.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, except req_ready = 1.
- Request acceptance: on req_valid && req_ready, latch we, funct3, addr, wdata, rd.
- Legal types:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other code is illegal: go to RESP with resp_err = 1.
- Misalignment: halfword with addr[0] = 1, or word with addr[1:0] != 0.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Write data: byte as {4{wdata[7:0]}}, half as {2{wdata[15:0]}}, word unchanged.
- Load extraction: select lane by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- FSM states: IDLE, REQ, WAIT, REQ2, WAIT2, RESP.
  - IDLE -> REQ on accept of a legal, aligned request.
  - IDLE -> RESP on illegal, or misaligned without the feature.
  - REQ: mem_req = 1, outputs stable until mem_gnt. On gnt, a store goes to RESP and a load goes to WAIT.
  - WAIT: on mem_rvalid, capture and extract data, go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. req_ready returns next cycle.
- Latency (aligned):
  - Load: 1 cycle (accept) + grant wait + rvalid wait + 1 cycle (RESP).
  - Store with immediate grant: resp_valid 2 cycles after accept.
- Stray mem_rvalid: ignored in every state except WAIT and WAIT2.
- Mid-operation reset: FSM returns to IDLE on that edge and mem_req drops. A later rvalid for the abandoned request is ignored.
- Address arithmetic: modulo 2^ADDR_W.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: a misaligned access is split into two word accesses.
  - First access: word at addr & ~3, upper-lane enables (REQ/WAIT).
  - Second access: word at (addr & ~3) + 4, lower-lane enables (REQ2/WAIT2). Address wraps from 0xFFFFFFFC to 0x00000000.
  - Load data is assembled from both rdata words, then extended. No resp_err.
  - Store data is rotated by addr[1:0]*8 across the two accesses.
- Undefined: misaligned access gives resp_err = 1, no bus request; REQ2 and WAIT2 are not synthesised.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_state_t.
  - Function be_gen(size, offset).
- Sub-module lsu_load_align: combinational lane select plus sign/zero extension of a 64-bit {hi, lo} word pair by offset and funct3. Used for both aligned and split paths.

Test Plan:
- LB at addr 0x103, mem_rdata = 0x80FF_1234 -> mem_addr = 0x100, mem_be = 4'b1000, resp_rdata = 0xFFFF_FF80.
- LHU at addr 0x102, mem_rdata = 0x8001_0000 -> resp_rdata = 0x0000_8001.
- SH at addr 0x22, wdata = 0x1234_ABCD -> mem_addr = 0x20, be = 4'b1100, mem_wdata = 0xABCD_ABCD, resp_valid with rdata = 0.
- mem_gnt held low 3 cycles on SW -> mem_req and all bus outputs stable for 4 cycles, req_ready = 0 throughout, single resp_valid.
- LW at addr 0x41 -> without the macro: resp_err = 1, mem_req never asserted. With the macro: accesses at 0x40 (be 1110) then 0x44 (be 0001); rdata 0x332211xx and 0xxxxxxx44 give resp_rdata = 0x44332211.
- Reset asserted in WAIT, then mem_rvalid pulses -> no resp_valid, req_ready = 1 after reset, next request served normally.
